// File: rtl/cook_sequencer.sv
// Cook-cycle FSM for the microwave controller: sequences keypad entry, countdown
// timer, magnetron and buzzer from button/door inputs and the 1 Hz timebase.
module cook_sequencer #(
  parameter int BEEP_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       door_closed,
  input  logic       timer_zero,
  input  logic       pgt_1Hz,
  output logic       enn,
  output logic       count_en,
  output logic       timer_clearn,
  output logic       mag_on,
  output logic       beep,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  state_t     next_state;
  logic [3:0] beep_cnt;
  logic       start_q, stop_q, clear_q, pgt_q;
  logic       start_rise, stop_rise, clear_rise, tick;
  logic       clear_pulse;
  logic       load_beep;

  // A held level yields exactly one event.
  assign start_rise = start_btn & ~start_q;
  assign stop_rise  = stop_btn  & ~stop_q;
  assign clear_rise = clear_btn & ~clear_q;
  assign tick       = pgt_1Hz   & ~pgt_q;

  assign state = state_r;

  always_comb begin
    next_state  = state_r;
    clear_pulse = 1'b0;
    load_beep   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_rise) begin
          clear_pulse = 1'b1;
        end else if (start_rise && door_closed && !timer_zero) begin
          next_state = COOK;
        end
      end
      COOK: begin
        // Clear while cooking only pauses; the time is kept.
        if (clear_rise || stop_rise) begin
          next_state = PAUSE;
        end else if (!door_closed) begin
          next_state = PAUSE;
        end else if (timer_zero) begin
          next_state = DONE;
          load_beep  = 1'b1;
        end
      end
      PAUSE: begin
        // Cancel takes precedence over a simultaneous resume.
        if (stop_rise || clear_rise) begin
          next_state  = IDLE;
          clear_pulse = 1'b1;
        end else if (start_rise && door_closed && !timer_zero) begin
          next_state = COOK;
        end
      end
      DONE: begin
        if (start_rise || stop_rise || clear_rise || !door_closed) begin
          next_state = IDLE;
        end else if (tick && beep_cnt == 4'd1) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      enn          <= 1'b0;
      count_en     <= 1'b0;
      timer_clearn <= 1'b1;
      mag_on       <= 1'b0;
      beep         <= 1'b0;
      beep_cnt     <= 4'd0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      clear_q      <= 1'b0;
      pgt_q        <= 1'b0;
    end else begin
      start_q      <= start_btn;
      stop_q       <= stop_btn;
      clear_q      <= clear_btn;
      pgt_q        <= pgt_1Hz;
      state_r      <= next_state;
      // Outputs follow the next state so they switch on the same edge as state.
      enn          <= (next_state != IDLE);
      count_en     <= (next_state == COOK);
      mag_on       <= (next_state == COOK);
      beep         <= (next_state == DONE);
      timer_clearn <= ~clear_pulse;
      if (load_beep) begin
        beep_cnt <= 4'(BEEP_SEC);
      end else if (state_r == DONE && tick && beep_cnt != 4'd0) begin
        beep_cnt <= beep_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: linear stimulus with immediate assertions
// against hand-computed expected values.
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       door_closed = 1'b1;
  logic       timer_zero = 1'b0;
  logic       pgt_1Hz = 1'b0;
  logic       enn, count_en, timer_clearn, mag_on, beep;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  cook_sequencer #(.BEEP_SEC(3)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .door_closed(door_closed), .timer_zero(timer_zero),
    .pgt_1Hz(pgt_1Hz), .enn(enn), .count_en(count_en), .timer_clearn(timer_clearn),
    .mag_on(mag_on), .beep(beep), .state(state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns so outputs are stable and inputs change off-edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {enn, count_en, mag_on, beep} for compact checks.
  function automatic logic [3:0] outs();
    return {enn, count_en, mag_on, beep};
  endfunction

  initial begin
    // Power-on reset
    rst = 1'b1;
    #1;
    chk("reset_state", 4'(state), 4'd0);
    chk("reset_outs", outs(), 4'b0000);
    chk("reset_clearn", 4'(timer_clearn), 4'd1);
    step(2);
    rst = 1'b0;
    step(1);

    // IDLE: start with door open is ignored
    door_closed = 1'b0; start_btn = 1'b1;
    step(1);
    chk("idle_door_open_state", 4'(state), 4'd0);
    chk("idle_door_open_mag", 4'(mag_on), 4'd0);
    start_btn = 1'b0; door_closed = 1'b1;
    step(1);
    // IDLE: start with timer at zero is ignored
    timer_zero = 1'b1; start_btn = 1'b1;
    step(1);
    chk("idle_tz_state", 4'(state), 4'd0);
    start_btn = 1'b0; timer_zero = 1'b0;
    step(1);

    // IDLE clear held high: exactly one clear pulse
    clear_btn = 1'b1;
    step(1);
    chk("idle_clear_pulse", 4'(timer_clearn), 4'd0);
    chk("idle_clear_state", 4'(state), 4'd0);
    step(1);
    chk("idle_clear_end", 4'(timer_clearn), 4'd1);
    step(2);
    chk("idle_clear_held", 4'(timer_clearn), 4'd1);
    clear_btn = 1'b0;
    step(1);

    // Start held 5 cycles: one transition to COOK
    start_btn = 1'b1;
    step(1);
    chk("cook_state", 4'(state), 4'd1);
    chk("cook_outs", outs(), 4'b1110);
    step(4);
    chk("cook_held_state", 4'(state), 4'd1);
    start_btn = 1'b0;
    step(1);

    // Door opens mid-cook: PAUSE, then resume
    door_closed = 1'b0;
    step(1);
    chk("door_pause_state", 4'(state), 4'd2);
    chk("door_pause_outs", outs(), 4'b1000);
    door_closed = 1'b1;
    step(1);
    chk("pause_hold_state", 4'(state), 4'd2);
    start_btn = 1'b1;
    step(1);
    chk("resume_state", 4'(state), 4'd1);
    chk("resume_mag", 4'(mag_on), 4'd1);
    start_btn = 1'b0;
    step(1);

    // Timer reaches zero: DONE, beep for 3 ticks
    timer_zero = 1'b1;
    step(1);
    chk("done_state", 4'(state), 4'd3);
    chk("done_outs", outs(), 4'b1001);
    for (int t = 1; t <= 3; t++) begin
      pgt_1Hz = 1'b1;
      step(1);
      if (t < 3) begin
        chk("done_tick_state", 4'(state), 4'd3);
        chk("done_tick_beep", 4'(beep), 4'd1);
      end else begin
        chk("done_exit_state", 4'(state), 4'd0);
        chk("done_exit_outs", outs(), 4'b0000);
      end
      pgt_1Hz = 1'b0;
      step(2);
    end
    chk("done_exit_noclear", 4'(timer_clearn), 4'd1);
    timer_zero = 1'b0;
    step(1);

    // PAUSE via stop, then stop again cancels with a one-cycle clear
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    stop_btn = 1'b1;
    step(1);
    chk("stop_pause_state", 4'(state), 4'd2);
    stop_btn = 1'b0;
    step(1);
    stop_btn = 1'b1;
    step(1);
    chk("cancel_state", 4'(state), 4'd0);
    chk("cancel_enn", 4'(enn), 4'd0);
    chk("cancel_clearn", 4'(timer_clearn), 4'd0);
    step(1);
    chk("cancel_clearn_end", 4'(timer_clearn), 4'd1);
    stop_btn = 1'b0;
    step(1);

    // Clear in COOK pauses without clearing
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    clear_btn = 1'b1;
    step(1);
    chk("cook_clear_state", 4'(state), 4'd2);
    chk("cook_clear_clearn", 4'(timer_clearn), 4'd1);
    clear_btn = 1'b0;
    step(1);
    // Stop and start together in PAUSE: cancel wins
    stop_btn = 1'b1; start_btn = 1'b1;
    step(1);
    chk("cancel_wins_state", 4'(state), 4'd0);
    chk("cancel_wins_clearn", 4'(timer_clearn), 4'd0);
    stop_btn = 1'b0; start_btn = 1'b0;
    step(1);

    // DONE exits immediately on door open
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0; timer_zero = 1'b1;
    step(1);
    chk("done2_state", 4'(state), 4'd3);
    door_closed = 1'b0;
    step(1);
    chk("done_door_exit", 4'(state), 4'd0);
    chk("done_door_beep", 4'(beep), 4'd0);
    door_closed = 1'b1; timer_zero = 1'b0;
    step(1);

    // Asynchronous reset mid-cook
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    chk("pre_rst_mag", 4'(mag_on), 4'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", 4'(state), 4'd0);
    chk("async_rst_outs", outs(), 4'b0000);
    chk("async_rst_clearn", 4'(timer_clearn), 4'd1);
    step(1);
    rst = 1'b0;
    step(1);
    chk("post_rst_state", 4'(state), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
